// File: rtl/bcd_time_counter_if.sv
// Front-panel controls in, display digits out, for the wall-clock time core.
// Latency: none (wires only).
// Backpressure: none; levels and registered outputs only.
interface bcd_time_counter_if;
    logic       set_en;
    logic       inc_min;
    logic       inc_hour;
    logic       mode24;
    logic [3:0] hourten;
    logic [3:0] hourone;
    logic [3:0] mintens;
    logic [3:0] minones;
    logic       pm;
    logic       colon;
    logic       sec_tick;

    modport master (
        output set_en, inc_min, inc_hour, mode24,
        input  hourten, hourone, mintens, minones, pm, colon, sec_tick
    );

    modport slave (
        input  set_en, inc_min, inc_hour, mode24,
        output hourten, hourone, mintens, minones, pm, colon, sec_tick
    );
endinterface

// File: rtl/bcd_time_counter.sv
// BCD wall-clock core: 1 Hz prescaler, sec/min/hour counters, set buttons, 12/24h display.
// Latency: counters move on the sec_tick edge, digits one cycle later; buttons 3 cycles + 1.
// Backpressure: none; free-running, buttons are edge-detected levels.
module bcd_time_counter #(
    parameter int DIV = 10_000_000
) (
    input  logic              ADC_CLK_10,
    input  logic              Reset,
    bcd_time_counter_if.slave bus
);
    localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);

    // synchroniser chains; buttons carry a third flop for edge detection
    logic r_set_s1, r_set_s2, r_mode_s1, r_mode_s2;
    logic r_min_s1, r_min_s2, r_min_s3, r_hour_s1, r_hour_s2, r_hour_s3;

    // internal time state
    logic [PW-1:0] r_presc;
    logic [3:0]    r_sec_ten, r_sec_one, r_min_ten, r_min_one, r_hour_ten, r_hour_one;

    // registered outputs
    logic [3:0] r_hourten, r_hourone, r_mintens, r_minones;
    logic       r_pm, r_colon, r_sec_tick;

    logic          w_run, w_term, w_sec_wrap, w_min_wrap, w_min_inc, w_hour_inc;
    logic          w_min_edge, w_hour_edge;
    logic [PW-1:0] w_presc_nxt;
    logic [4:0]    w_hour_bin, w_disp_bin;
    logic [3:0]    w_disp_ten, w_disp_one;

    // bring the asynchronous front-panel levels into the clock domain
    always_ff @(posedge ADC_CLK_10 or posedge Reset) begin
        if (Reset) begin
            r_set_s1  <= 1'b0; r_set_s2  <= 1'b0;
            r_mode_s1 <= 1'b0; r_mode_s2 <= 1'b0;
            r_min_s1  <= 1'b0; r_min_s2  <= 1'b0; r_min_s3  <= 1'b0;
            r_hour_s1 <= 1'b0; r_hour_s2 <= 1'b0; r_hour_s3 <= 1'b0;
        end else begin
            r_set_s1  <= bus.set_en;   r_set_s2  <= r_set_s1;
            r_mode_s1 <= bus.mode24;   r_mode_s2 <= r_mode_s1;
            r_min_s1  <= bus.inc_min;  r_min_s2  <= r_min_s1;  r_min_s3  <= r_min_s2;
            r_hour_s1 <= bus.inc_hour; r_hour_s2 <= r_hour_s1; r_hour_s3 <= r_hour_s2;
        end
    end

    // carry chain decode: prescaler terminal count ripples into sec/min/hour increments
    always_comb begin
        w_min_edge  = r_min_s2 & ~r_min_s3;
        w_hour_edge = r_hour_s2 & ~r_hour_s3;
        w_run       = ~r_set_s2;
        w_term      = w_run && (r_presc == P_LAST);
        w_presc_nxt = '0;
        if (w_run && !w_term) w_presc_nxt = r_presc + 1'b1;
        w_sec_wrap  = w_term && (r_sec_ten == 4'd5) && (r_sec_one == 4'd9);
        w_min_wrap  = (r_min_ten == 4'd5) && (r_min_one == 4'd9);
        // set-mode minute presses never carry into hours
        w_min_inc   = w_sec_wrap | (r_set_s2 & w_min_edge);
        w_hour_inc  = (w_sec_wrap & w_min_wrap) | (r_set_s2 & w_hour_edge);
    end

    // prescaler and seconds: free-running in run mode, held at zero in set mode
    always_ff @(posedge ADC_CLK_10 or posedge Reset) begin
        if (Reset) begin
            r_presc    <= '0;
            r_sec_ten  <= 4'd0;
            r_sec_one  <= 4'd0;
            r_sec_tick <= 1'b0;
        end else begin
            r_presc    <= w_presc_nxt;
            r_sec_tick <= w_term;
            if (!w_run) begin
                r_sec_ten <= 4'd0;
                r_sec_one <= 4'd0;
            end else if (w_term) begin
                if (r_sec_one == 4'd9) begin
                    r_sec_one <= 4'd0;
                    r_sec_ten <= (r_sec_ten == 4'd5) ? 4'd0 : r_sec_ten + 4'd1;
                end else begin
                    r_sec_one <= r_sec_one + 4'd1;
                end
            end
        end
    end

    // minutes and hours advance on a carry or a set-mode button edge
    always_ff @(posedge ADC_CLK_10 or posedge Reset) begin
        if (Reset) begin
            r_min_ten  <= 4'd0;
            r_min_one  <= 4'd0;
            r_hour_ten <= 4'd0;
            r_hour_one <= 4'd0;
        end else begin
            if (w_min_inc) begin
                if (r_min_one == 4'd9) begin
                    r_min_one <= 4'd0;
                    r_min_ten <= (r_min_ten == 4'd5) ? 4'd0 : r_min_ten + 4'd1;
                end else begin
                    r_min_one <= r_min_one + 4'd1;
                end
            end
            if (w_hour_inc) begin
                if (r_hour_ten == 4'd2 && r_hour_one == 4'd3) begin
                    r_hour_ten <= 4'd0;
                    r_hour_one <= 4'd0;
                end else if (r_hour_one == 4'd9) begin
                    r_hour_ten <= r_hour_ten + 4'd1;
                    r_hour_one <= 4'd0;
                end else begin
                    r_hour_one <= r_hour_one + 4'd1;
                end
            end
        end
    end

    // 24h to 12h mapping: 0 -> 12, 13..23 -> 1..11, others unchanged
    always_comb begin
        w_hour_bin = 5'(r_hour_ten) * 5'd10 + 5'(r_hour_one);
        w_disp_bin = w_hour_bin;
        if (!r_mode_s2) begin
            if (w_hour_bin == 5'd0)      w_disp_bin = 5'd12;
            else if (w_hour_bin > 5'd12) w_disp_bin = w_hour_bin - 5'd12;
        end
        w_disp_ten = 4'd0;
        if (w_disp_bin >= 5'd20)      w_disp_ten = 4'd2;
        else if (w_disp_bin >= 5'd10) w_disp_ten = 4'd1;
        w_disp_one = 4'(w_disp_bin - 5'(w_disp_ten) * 5'd10);
    end

    // display registers; colon tracks the prescaler value being loaded this edge
    always_ff @(posedge ADC_CLK_10 or posedge Reset) begin
        if (Reset) begin
            r_hourten <= 4'd0;
            r_hourone <= 4'd0;
            r_mintens <= 4'd0;
            r_minones <= 4'd0;
            r_pm      <= 1'b0;
            r_colon   <= 1'b1;
        end else begin
            r_hourten <= w_disp_ten;
            r_hourone <= w_disp_one;
            r_mintens <= r_min_ten;
            r_minones <= r_min_one;
            r_pm      <= ~r_mode_s2 && (w_hour_bin >= 5'd12);
            r_colon   <= r_set_s2 | (w_presc_nxt < P_HALF);
        end
    end

    assign bus.hourten  = r_hourten;
    assign bus.hourone  = r_hourone;
    assign bus.mintens  = r_mintens;
    assign bus.minones  = r_minones;
    assign bus.pm       = r_pm;
    assign bus.colon    = r_colon;
    assign bus.sec_tick = r_sec_tick;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with DIV=4.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: none.
module tb_bcd_time_counter;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bcd_time_counter_if bus();

    bcd_time_counter #(.DIV(DIV)) dut (
        .ADC_CLK_10 (clk),
        .Reset      (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] digits();
        return {16'h0, bus.hourten, bus.hourone, bus.mintens, bus.minones};
    endfunction

    function automatic logic [31:0] hours();
        return {24'h0, bus.hourten, bus.hourone};
    endfunction

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            bus.inc_min = 1'b1; cyc(1);
            bus.inc_min = 1'b0; cyc(1);
        end
    endtask

    task automatic press_hour(input int n);
        for (int i = 0; i < n; i++) begin
            bus.inc_hour = 1'b1; cyc(1);
            bus.inc_hour = 1'b0; cyc(1);
        end
    endtask

    task automatic wait_tick(input string tag);
        logic found;
        int   cnt;
        found = 1'b0;
        cnt   = 0;
        while (!found && cnt < 3 * DIV) begin
            @(negedge clk);
            cnt++;
            if (bus.sec_tick === 1'b1) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.set_en   = 1'b0;
        bus.inc_min  = 1'b0;
        bus.inc_hour = 1'b0;
        bus.mode24   = 1'b1;

        // reset state
        cyc(3);
        chk("rst_digits", digits(), 32'h0000);
        chk("rst_colon", 32'(bus.colon), 32'd1);
        chk("rst_tick", 32'(bus.sec_tick), 32'd0);
        chk("rst_pm", 32'(bus.pm), 32'd0);

        // first ticks: pulse every DIV cycles, colon high for the first half
        rst = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            cyc(1);
            chk("run_tick", 32'(bus.sec_tick), (n % 4 == 0) ? 32'd1 : 32'd0);
            chk("run_colon", 32'(bus.colon), (n % 4 < 2) ? 32'd1 : 32'd0);
        end
        chk("sec_two", {24'h0, dut.r_sec_ten, dut.r_sec_one}, 32'h02);

        // set mode: 60 minute presses wrap with no hour carry
        bus.set_en = 1'b1;
        cyc(3);
        press_min(60);
        cyc(4);
        chk("min_wrap_nocarry", digits(), 32'h0000);
        press_min(1);
        press_hour(25);
        cyc(4);
        chk("set_digits", digits(), 32'h0101);
        chk("set_tick", 32'(bus.sec_tick), 32'd0);
        chk("set_colon", 32'(bus.colon), 32'd1);

        // simultaneous edges both apply
        bus.inc_min  = 1'b1;
        bus.inc_hour = 1'b1;
        cyc(1);
        bus.inc_min  = 1'b0;
        bus.inc_hour = 1'b0;
        cyc(5);
        chk("both_edges", digits(), 32'h0202);

        // preload 23:59, run 60 seconds to the full wrap
        press_hour(21);
        press_min(57);
        cyc(4);
        chk("preload", digits(), 32'h2359);
        bus.set_en = 1'b0;
        cyc(5);
        chk("resume_early", 32'(bus.sec_tick), 32'd0);
        cyc(1);
        chk("resume_tick", 32'(bus.sec_tick), 32'd1);
        for (int k = 2; k <= 59; k++) wait_tick("tick_wait");
        cyc(1);
        chk("wrap_pre", digits(), 32'h2359);
        wait_tick("tick_wait");
        chk("wrap_latency", digits(), 32'h2359);
        cyc(1);
        chk("wrap", digits(), 32'h0000);

        // 12-hour mapping and mode-switch latency
        bus.set_en = 1'b1;
        cyc(3);
        bus.mode24 = 1'b0;
        cyc(2);
        chk("mode_lat", hours(), 32'h00);
        cyc(1);
        chk("h00", hours(), 32'h12);
        chk("h00_pm", 32'(bus.pm), 32'd0);
        press_hour(11); cyc(4);
        chk("h11", hours(), 32'h11);
        chk("h11_pm", 32'(bus.pm), 32'd0);
        press_hour(1); cyc(4);
        chk("h12", hours(), 32'h12);
        chk("h12_pm", 32'(bus.pm), 32'd1);
        press_hour(1); cyc(4);
        chk("h13", hours(), 32'h01);
        chk("h13_pm", 32'(bus.pm), 32'd1);
        press_hour(10); cyc(4);
        chk("h23", hours(), 32'h11);
        chk("h23_pm", 32'(bus.pm), 32'd1);
        bus.mode24 = 1'b1;
        cyc(4);
        chk("h23_24", hours(), 32'h23);
        chk("h23_24_pm", 32'(bus.pm), 32'd0);

        // presses outside set mode are ignored
        bus.set_en = 1'b0;
        cyc(3);
        press_min(1);
        cyc(4);
        chk("run_press", digits(), 32'h2300);

        // asynchronous reset mid-count at 12:34
        bus.set_en = 1'b1;
        cyc(3);
        press_hour(13);
        press_min(34);
        cyc(4);
        bus.set_en = 1'b0;
        cyc(6);
        chk("pre_reset", digits(), 32'h1234);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", digits(), 32'h0000);
        bus.inc_min = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(6);
        chk("held_button", digits(), 32'h0000);
        bus.inc_min = 1'b0;
        cyc(4);
        chk("held_release", digits(), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
